// File: rtl/timer_ctrl_fsm_if.sv
// ----------------------------------------------------------------------------
// timer_ctrl_fsm_if
// Purpose : groups the control inputs and status outputs of timer_ctrl_fsm
//           into a single bundle so that the button/debounce side and the
//           display/BCD side see one coherent port.
// Params  : CNT_W - width of load_val, count and lap_count.
// Signals : start, stop, clear, mode_down, load_val, lap   (controller -> timer)
//           state, count_en, tick, count, done, done_pulse,
//           lap_count, lap_valid                          (timer -> consumers)
// Modports: master - the block issuing requests and consuming status.
//           slave  - the timer itself.
// ----------------------------------------------------------------------------
interface timer_ctrl_fsm_if #(
   parameter int CNT_W = 8
);
   logic             start;
   logic             stop;
   logic             clear;
   logic             mode_down;
   logic [CNT_W-1:0] load_val;
   logic             lap;

   logic [1:0]       state;
   logic             count_en;
   logic             tick;
   logic [CNT_W-1:0] count;
   logic             done;
   logic             done_pulse;
   logic [CNT_W-1:0] lap_count;
   logic             lap_valid;

   modport master (
      output start, stop, clear, mode_down, load_val, lap,
      input  state, count_en, tick, count, done, done_pulse, lap_count, lap_valid
   );

   modport slave (
      input  start, stop, clear, mode_down, load_val, lap,
      output state, count_en, tick, count, done, done_pulse, lap_count, lap_valid
   );
endinterface

// File: rtl/timer_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// timer_ctrl_fsm
// Purpose : stopwatch/timer control FSM with an integrated tick prescaler,
//           an owned count register, up or down counting, and a terminal DONE
//           state that emits a single-cycle completion pulse.
// Params  : CNT_W    - count / load value / lap width.
//           TICK_DIV - clk cycles per count tick (>= 1).
//           MAX_VAL  - terminal value in up mode (1 .. 2^CNT_W-1).
// Ports   : clk   - system clock, rising edge.
//           rst_n - synchronous active-low reset.
//           bus   - timer_ctrl_fsm_if.slave:
//                     in : start, stop, clear, mode_down, load_val, lap
//                     out: state (IDLE=00 RUNNING=01 PAUSED=10 DONE=11),
//                          count_en, tick, count, done, done_pulse,
//                          lap_count, lap_valid
// Options : define TIMER_LAP_HOLD_EN to build the lap capture register;
//           otherwise lap is ignored and lap_count/lap_valid read as zero.
// ----------------------------------------------------------------------------
module timer_ctrl_fsm #(
   parameter int CNT_W    = 8,
   parameter int TICK_DIV = 4,
   parameter int MAX_VAL  = 10
) (
   input  logic           clk,
   input  logic           rst_n,
   timer_ctrl_fsm_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

   // A one-bit prescaler is kept even for TICK_DIV=1; it then simply stays 0.
   localparam int               PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] UP_LAST    = CNT_W'(MAX_VAL - 1);
   localparam logic [CNT_W-1:0] DOWN_LAST  = CNT_W'(1);

   state_t           state_reg,      state_next;
   logic [CNT_W-1:0] count_reg,      count_next;
   logic [PW-1:0]    presc_reg,      presc_next;
   logic             dir_reg,        dir_next;
   logic             done_pulse_reg, done_pulse_next;
   logic             tick_w;
   logic             terminal_w;

   // ------------------------------------------------------------------------
   // State and datapath registers. clear acts exactly like reset, but only
   // while rst_n is released.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n || bus.clear) begin
         state_reg      <= ST_IDLE;
         count_reg      <= '0;
         presc_reg      <= '0;
         dir_reg        <= 1'b0;
         done_pulse_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         count_reg      <= count_next;
         presc_reg      <= presc_next;
         dir_reg        <= dir_next;
         done_pulse_reg <= done_pulse_next;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state / datapath logic. Everything keys off the registered state,
   // so a tick landing in the same cycle as stop still updates the count.
   // ------------------------------------------------------------------------
   always_comb begin
      state_next      = state_reg;
      count_next      = count_reg;
      presc_next      = presc_reg;
      dir_next        = dir_reg;
      done_pulse_next = 1'b0;

      tick_w     = (state_reg == ST_RUN) && (presc_reg == PRESC_LAST);
      // The tick that would land on the terminal value is the one that ends
      // the run, so count never steps past it.
      terminal_w = tick_w && (dir_reg ? (count_reg == DOWN_LAST)
                                      : (count_reg == UP_LAST));

      case (state_reg)
         ST_IDLE: begin
            if (bus.start) begin
               dir_next   = bus.mode_down;
               presc_next = '0;
               count_next = bus.mode_down ? bus.load_val : '0;
               // A zero load in down mode is already at its terminal value.
               if (bus.mode_down && (bus.load_val == '0))
                  state_next = ST_DONE;
               else
                  state_next = ST_RUN;
            end
         end

         ST_RUN: begin
            presc_next = tick_w ? '0 : presc_reg + PW'(1);
            if (tick_w)
               count_next = dir_reg ? count_reg - CNT_W'(1)
                                    : count_reg + CNT_W'(1);
            // Reaching the terminal value takes precedence over a pause.
            if (terminal_w)
               state_next = ST_DONE;
            else if (bus.stop)
               state_next = ST_PAUSE;
         end

         ST_PAUSE: begin
            // Prescaler and count hold so a partial tick period survives.
            if (bus.start)
               state_next = ST_RUN;
         end

         ST_DONE: begin
            // Only clear or reset leave this state.
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase

      done_pulse_next = (state_next == ST_DONE) && (state_reg != ST_DONE);
   end

   assign bus.state      = state_reg;
   assign bus.count      = count_reg;
   assign bus.count_en   = (state_reg == ST_RUN);
   assign bus.tick       = tick_w;
   assign bus.done       = (state_reg == ST_DONE);
   assign bus.done_pulse = done_pulse_reg;

   // ------------------------------------------------------------------------
   // Lap capture: snapshots the registered count while a run is live.
   // ------------------------------------------------------------------------
`ifdef TIMER_LAP_HOLD_EN
   logic [CNT_W-1:0] lap_count_reg;
   logic             lap_valid_reg;

   always_ff @(posedge clk) begin
      if (!rst_n || bus.clear) begin
         lap_count_reg <= '0;
         lap_valid_reg <= 1'b0;
      end else if (bus.lap && ((state_reg == ST_RUN) || (state_reg == ST_PAUSE))) begin
         lap_count_reg <= count_reg;
         lap_valid_reg <= 1'b1;
      end
   end

   assign bus.lap_count = lap_count_reg;
   assign bus.lap_valid = lap_valid_reg;
`else
   assign bus.lap_count = '0;
   assign bus.lap_valid = 1'b0;
`endif

endmodule
